alu_share_ctrl: RTL and testbench

Arbiter and sequencer that shares one `alu_8bit` datapath between two independent requesters. Each requester issues an operation (opcode, a, b) over a valid/ready handshake. The block grants the ALU round-robin, registers the operands into the ALU, captures the result and flags, and returns them on a per-requester response handshake. It sits between the two client engines and the single combinational ALU instance.

---
 rtl/alu_share_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Shares one combinational 8-bit ALU between two requesters with round-robin grant.
// Latency: accept at edge T, result captured at T+1, response valid from cycle T+2.
// Backpressure: response held in RESP until owner's rsp_ready; no requests accepted meanwhile.
module alu_share_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_opcode,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_opcode,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp_data,
    output logic [4:0] rsp_flags,
    output logic [2:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    input  logic       alu_sign,
    input  logic       alu_zero,
    input  logic       alu_carry,
    input  logic       alu_parity,
    input  logic       alu_overflow,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic       owner_q, owner_d;
    logic [2:0] alu_opcode_q, alu_opcode_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [4:0] rsp_flags_q, rsp_flags_d;

    logic       grant;
    logic       grant_vld;

    // Round-robin pick: a lone requester wins, a tie goes to the priority pointer.
    always_comb begin
        grant     = 1'b0;
        grant_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = prio_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Next-state, register loads and handshake outputs for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_data_d   = rsp_data_q;
        rsp_flags_d  = rsp_flags_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                // Readies are combinational, so keep them low while reset is held.
                req0_ready = !rst && req0_valid && !grant;
                req1_ready = !rst && req1_valid && grant;
                if (grant_vld) begin
                    state_d      = EXEC;
                    owner_d      = grant;
                    alu_opcode_d = grant ? req1_opcode : req0_opcode;
                    alu_a_d      = grant ? req1_a      : req0_a;
                    alu_b_d      = grant ? req1_b      : req0_b;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_out;
                rsp_flags_d = {alu_overflow, alu_parity, alu_carry, alu_zero, alu_sign};
                state_d     = RESP;
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            alu_opcode_q <= 3'd0;
            alu_a_q      <= 8'd0;
            alu_b_q      <= 8'd0;
            rsp_data_q   <= 8'd0;
            rsp_flags_q  <= 5'd0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            owner_q      <= owner_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a stand-in ALU closes the loop, a transaction-level model
// predicts grants, response timing and results, and a monitor compares every cycle.
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_opcode = 3'd0, req1_opcode = 3'd0;
    logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [4:0] rsp_flags;
    logic [2:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_sign, alu_zero, alu_carry, alu_parity, alu_overflow;
    logic       busy;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_sign(alu_sign), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_parity(alu_parity), .alu_overflow(alu_overflow),
        .busy(busy)
    );

    // Stand-in ALU: returns {result, overflow, parity, carry, zero, sign}.
    // Flag rules reproduce the reference vectors (ADD 7F+01, SUB 00-01, XOR 5A^5A).
    function automatic logic [12:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        w = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                        v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin r = a - b; c = (a < b); v = c; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = {a[6:0], 1'b0}; c = a[7]; end
            3'd6: begin r = {1'b0, a[7:1]}; c = a[0]; end
            default: r = ~a;
        endcase
        return {r, v, ~^r, c, (r == 8'd0), r[7]};
    endfunction

    always_comb begin
        {alu_out, alu_overflow, alu_parity, alu_carry, alu_zero, alu_sign} =
            alu_fn(alu_opcode, alu_a, alu_b);
    end

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic [4:0] flags;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic end_req = 1'b0;
    logic end_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor and reference model: one transaction outstanding at most; tie grants follow
    // a pointer that flips to the non-owner after each completed response.
    initial begin : monitor
        logic       m_busy, m_prio, m_owner, e_r0, e_r1, e_v0, e_v1;
        logic [2:0] m_op;
        logic [7:0] m_a, m_b;
        int         cyc, m_acc;
        exp_t       e;
        m_busy = 0; m_prio = 0; m_owner = 0; m_op = 0; m_a = 0; m_b = 0;
        cyc = 0; m_acc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0; m_prio = 0;
                sb.delete();
                chk("rst_busy", busy, 0);
                chk("rst_rsp_valids", {rsp0_valid, rsp1_valid}, 0);
                chk("rst_req_readys", {req0_ready, req1_ready}, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_rsp_flags", rsp_flags, 0);
                chk("rst_alu_regs", {alu_opcode, alu_a, alu_b}, 0);
            end else begin
                cyc++;
                e_r0 = 0; e_r1 = 0;
                if (!m_busy) begin
                    if (req0_valid && req1_valid) begin
                        e_r0 = !m_prio; e_r1 = m_prio;
                    end else begin
                        e_r0 = req0_valid; e_r1 = req1_valid;
                    end
                end
                chk("req0_ready", req0_ready, e_r0);
                chk("req1_ready", req1_ready, e_r1);
                chk("busy", busy, m_busy);
                e_v0 = m_busy && (cyc >= m_acc + 2) && !m_owner;
                e_v1 = m_busy && (cyc >= m_acc + 2) && m_owner;
                chk("rsp0_valid", rsp0_valid, e_v0);
                chk("rsp1_valid", rsp1_valid, e_v1);
                if (m_busy) chk("alu_operands", {alu_opcode, alu_a, alu_b}, {m_op, m_a, m_b});
                if ((e_v0 || e_v1) && sb.size() > 0) begin
                    chk("rsp_data", rsp_data, sb[0].data);
                    chk("rsp_flags", rsp_flags, sb[0].flags);
                    if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
                        void'(sb.pop_front());
                        m_busy = 0;
                        m_prio = ~m_owner;
                    end
                end
                if ((e_r0 && req0_valid) || (e_r1 && req1_valid)) begin
                    m_owner = e_r1;
                    m_op = e_r1 ? req1_opcode : req0_opcode;
                    m_a  = e_r1 ? req1_a : req0_a;
                    m_b  = e_r1 ? req1_b : req0_b;
                    e.id = m_owner;
                    {e.data, e.flags} = alu_fn(m_op, m_a, m_b);
                    sb.push_back(e);
                    m_busy = 1;
                    m_acc  = cyc;
                end
                if (end_req && !end_done) begin
                    chk("drain_sb_empty", sb.size(), 0);
                    chk("drain_idle", m_busy, 0);
                    end_done = 1;
                end
            end
        end
    end

    // Present one request and hold it until accepted (bounded), then drop valid.
    task automatic send(input logic id, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        bit acc;
        acc = 0;
        if (id) begin req1_opcode = op; req1_a = a; req1_b = b; req1_valid = 1; end
        else    begin req0_opcode = op; req0_a = a; req0_b = b; req0_valid = 1; end
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = id ? req1_ready : req0_ready;
        end
        @(posedge clk); #1;
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        bit a0, a1, seen;
        #1 rst = 1;
        idle_cycles(3);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        rsp0_ready = 1; rsp1_ready = 1;

        // Reference vectors: ADD overflow, SUB borrow, XOR zero.
        send(0, 3'b000, 8'h7F, 8'h01);
        idle_cycles(4);
        send(1, 3'b001, 8'h00, 8'h01);
        idle_cycles(4);
        send(0, 3'b100, 8'h5A, 8'h5A);
        idle_cycles(4);

        // Contention: both valid continuously, grants must alternate.
        req0_opcode = 3'd0; req0_a = 8'h11; req0_b = 8'h22;
        req1_opcode = 3'd3; req1_a = 8'hF0; req1_b = 8'h0F;
        req0_valid = 1; req1_valid = 1;
        idle_cycles(14);
        req0_valid = 0; req1_valid = 0;
        idle_cycles(4);

        // Back-pressure: owner 0 stalls RESP while requester 1 waits.
        rsp0_ready = 0;
        send(0, 3'b010, 8'hC3, 8'h5F);
        req1_opcode = 3'd5; req1_a = 8'h81; req1_b = 8'h00; req1_valid = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rsp0_valid;
        end
        idle_cycles(5);
        rsp0_ready = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = req1_ready;
        end
        @(posedge clk); #1;
        req1_valid = 0;
        idle_cycles(4);

        // Reset during EXEC: operation discarded, pointer back to 0.
        send(1, 3'b000, 8'h01, 8'h02);
        #1 rst = 1;
        idle_cycles(2);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        req0_opcode = 3'd6; req0_a = 8'h03; req0_b = 8'h00;
        req1_opcode = 3'd7; req1_a = 8'h55; req1_b = 8'h00;
        req0_valid = 1; req1_valid = 1;
        idle_cycles(1);
        req0_valid = 0; req1_valid = 0;
        idle_cycles(4);

        // Randomized traffic with random response back-pressure.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (a0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_opcode = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
            end
            if (a1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_opcode = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end

        // Drain with a bounded wait, then close out.
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = !busy;
        end
        @(posedge clk); #1;
        end_req = 1;
        idle_cycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
